// File: rtl/vga_vsync_gen.sv
// vga_vsync_gen -- vertical timing stage of the VGA pipeline.
//
// Counts end-of-line pulses from the horizontal stage and walks the vertical
// frame through visible, front-porch, sync and back-porch regions. States
// whose length is zero are skipped in the same cycle, and a visible length of
// zero is treated as one line. Timing inputs are captured into shadow
// registers during reset and whenever a new frame begins, so mid-frame input
// changes only take effect from the next frame.
//
// Ports:
//   clk_i            pixel clock, shared with the horizontal stage
//   rst_i            synchronous active-high reset
//   line_end_i       one-cycle pulse on the last pixel clock of each line
//   visible_lines_i  number of active lines
//   front_porch_i    number of front-porch lines
//   sync_pulse_i     number of vsync lines
//   back_porch_i     number of back-porch lines
//   Ypos_o           visible row index, 0 outside the visible region
//   vsync_o          vsync pin level (VSYNC_POL during sync, inverse otherwise)
//   vblank_o         1 outside the visible region
//   frame_start_o    one-cycle pulse on entry to row 0 of a frame
//   frame_cnt_o      completed-frame counter
//
// Optional feature macro: VGA_VSYNC_FRAME_CNT_EN. When defined, frame_cnt_o
// counts frame wraps (modulo 2^16); otherwise it is tied to zero.

module vga_vsync_gen #(
  parameter int   W         = 12,
  parameter logic VSYNC_POL = 1'b0
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         line_end_i,
  input  logic [W-1:0] visible_lines_i,
  input  logic [W-1:0] front_porch_i,
  input  logic [W-1:0] sync_pulse_i,
  input  logic [W-1:0] back_porch_i,
  output logic [W-1:0] Ypos_o,
  output logic         vsync_o,
  output logic         vblank_o,
  output logic         frame_start_o,
  output logic [15:0]  frame_cnt_o
);

  typedef enum logic [1:0] {S_VIS, S_FP, S_SYNC, S_BP} state_e;

  state_e         state_q, state_d, advState;
  logic [W-1:0]   lineCnt_q, lineCnt_d;
  logic [W-1:0]   visLen_q, fpLen_q, syncLen_q, bpLen_q;
  logic [W-1:0]   curLen, visInEff;
  logic           firstFrame_q;
  logic           frameWrap;
  logic [W-1:0]   Ypos_q;
  logic           vsync_q, vblank_q, frameStart_q;

  // A zero visible length would make the frame degenerate, so it is stored
  // as a single visible line.
  assign visInEff = (visible_lines_i == '0) ? W'(1) : visible_lines_i;

  // Length of the region currently being walked. Porch/sync states are only
  // ever entered when their shadow length is nonzero, so curLen - 1 never
  // underflows.
  always_comb begin
    curLen = visLen_q;
    unique case (state_q)
      S_VIS:   curLen = visLen_q;
      S_FP:    curLen = fpLen_q;
      S_SYNC:  curLen = syncLen_q;
      S_BP:    curLen = bpLen_q;
      default: curLen = visLen_q;
    endcase
  end

  // Next nonzero-length region after the current one, skipping empty ones.
  always_comb begin
    advState = S_VIS;
    unique case (state_q)
      S_VIS: begin
        if (fpLen_q != '0)        advState = S_FP;
        else if (syncLen_q != '0) advState = S_SYNC;
        else if (bpLen_q != '0)   advState = S_BP;
        else                      advState = S_VIS;
      end
      S_FP: begin
        if (syncLen_q != '0)      advState = S_SYNC;
        else if (bpLen_q != '0)   advState = S_BP;
        else                      advState = S_VIS;
      end
      S_SYNC: begin
        if (bpLen_q != '0)        advState = S_BP;
        else                      advState = S_VIS;
      end
      S_BP:    advState = S_VIS;
      default: advState = S_VIS;
    endcase
  end

  // Line counting and region advance. A frame wrap is any advance that lands
  // back in the visible region, including VIS->VIS when all porches are empty.
  always_comb begin
    state_d   = state_q;
    lineCnt_d = lineCnt_q;
    frameWrap = 1'b0;
    if (line_end_i) begin
      if (lineCnt_q == curLen - W'(1)) begin
        lineCnt_d = '0;
        state_d   = advState;
        frameWrap = (advState == S_VIS);
      end else begin
        lineCnt_d = lineCnt_q + W'(1);
      end
    end
  end

  // State, shadow timing and registered outputs. Outputs are derived from the
  // next-state values so they change on the same edge as the line count.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= S_VIS;
      lineCnt_q    <= '0;
      visLen_q     <= visInEff;
      fpLen_q      <= front_porch_i;
      syncLen_q    <= sync_pulse_i;
      bpLen_q      <= back_porch_i;
      firstFrame_q <= 1'b1;
      Ypos_q       <= '0;
      vblank_q     <= 1'b0;
      vsync_q      <= ~VSYNC_POL;
      frameStart_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      lineCnt_q    <= lineCnt_d;
      if (frameWrap) begin
        visLen_q  <= visInEff;
        fpLen_q   <= front_porch_i;
        syncLen_q <= sync_pulse_i;
        bpLen_q   <= back_porch_i;
      end
      firstFrame_q <= 1'b0;
      Ypos_q       <= (state_d == S_VIS) ? lineCnt_d : '0;
      vblank_q     <= (state_d != S_VIS);
      vsync_q      <= (state_d == S_SYNC) ? VSYNC_POL : ~VSYNC_POL;
      frameStart_q <= firstFrame_q | frameWrap;
    end
  end

  assign Ypos_o        = Ypos_q;
  assign vsync_o       = vsync_q;
  assign vblank_o      = vblank_q;
  assign frame_start_o = frameStart_q;

`ifdef VGA_VSYNC_FRAME_CNT_EN
  logic [15:0] frameCnt_q;

  // Completed-frame counter; wraps naturally at 16 bits.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      frameCnt_q <= '0;
    end else if (frameWrap) begin
      frameCnt_q <= frameCnt_q + 16'd1;
    end
  end

  assign frame_cnt_o = frameCnt_q;
`else
  assign frame_cnt_o = 16'h0000;
`endif

endmodule

// File: tb/tb_vga_vsync_gen.sv
// tb_vga_vsync_gen -- self-checking bench for vga_vsync_gen.
//
// A reference model tracks the line index within the frame and the frame
// parameters captured at each frame start; expected outputs are derived from
// which region that index falls into. Stimulus uses randomised gaps between
// line_end pulses plus directed scenarios (640x480, zero-length states,
// mid-frame reconfiguration, reset during sync, back-to-back pulses).

module tb_vga_vsync_gen;

  localparam int W = 12;

  logic         clk;
  logic         rst;
  logic         lineEnd;
  logic [W-1:0] visIn, fpIn, syncIn, bpIn;
  logic [W-1:0] Ypos;
  logic         vsync, vblank, frameStart;
  logic [15:0]  frameCnt;

  int nChecks = 0;
  int nPass   = 0;

  // Reference model state: captured frame lengths and line index in frame.
  int mVis, mFp, mSync, mBp;
  int mIdx;
  bit mFirst;
  bit mFs;
  int mFrames;

  // Observations gathered over directed segments.
  int obsVsyncLines, obsBlankLines, obsMaxY, obsFsCount;

  vga_vsync_gen #(.W(W), .VSYNC_POL(1'b0)) dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .line_end_i      (lineEnd),
    .visible_lines_i (visIn),
    .front_porch_i   (fpIn),
    .sync_pulse_i    (syncIn),
    .back_porch_i    (bpIn),
    .Ypos_o          (Ypos),
    .vsync_o         (vsync),
    .vblank_o        (vblank),
    .frame_start_o   (frameStart),
    .frame_cnt_o     (frameCnt)
  );

  // Free-running pixel clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    nChecks++;
    if (observed === expected) begin
      nPass++;
    end else begin
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", tag, observed, expected, $time);
    end
  endtask

  // Capture frame lengths from the current inputs, as the design does at
  // frame start.
  task automatic modelLatch();
    mVis  = (visIn == 0) ? 1 : int'(visIn);
    mFp   = int'(fpIn);
    mSync = int'(syncIn);
    mBp   = int'(bpIn);
  endtask

  // Advance the model by one clock edge.
  task automatic modelEdge(input bit le, input bit r);
    if (r) begin
      mIdx    = 0;
      modelLatch();
      mFirst  = 1'b1;
      mFs     = 1'b0;
      mFrames = 0;
    end else begin
      mFs    = mFirst;
      mFirst = 1'b0;
      if (le) begin
        mIdx++;
        if (mIdx >= mVis + mFp + mSync + mBp) begin
          mIdx = 0;
          modelLatch();
          mFs = 1'b1;
          mFrames++;
        end
      end
    end
  endtask

  // Compare every DUT output against the region the model index lies in.
  task automatic checkAll();
    int ey;
    bit eb, es;
    ey = 0;
    eb = 1'b1;
    es = 1'b1;
    if (mIdx < mVis) begin
      ey = mIdx;
      eb = 1'b0;
    end else if (mIdx >= mVis + mFp && mIdx < mVis + mFp + mSync) begin
      es = 1'b0;
    end
    checkOutput("Ypos", 32'(Ypos), 32'(ey));
    checkOutput("vblank", 32'(vblank), 32'(eb));
    checkOutput("vsync", 32'(vsync), 32'(es));
    checkOutput("frame_start", 32'(frameStart), 32'(mFs));
`ifdef VGA_VSYNC_FRAME_CNT_EN
    checkOutput("frame_cnt", 32'(frameCnt), 32'(mFrames & 16'hFFFF));
`else
    checkOutput("frame_cnt", 32'(frameCnt), 32'd0);
`endif
  endtask

  // One clock: drive inputs on the falling edge, update the model on the
  // rising edge, check outputs just after it.
  task automatic applyStimulus(input bit le, input bit r);
    @(negedge clk);
    lineEnd = le;
    rst     = r;
    @(posedge clk);
    modelEdge(le, r);
    #1;
    checkAll();
    if (le && !r) begin
      if (vsync == 1'b0) obsVsyncLines++;
      if (vblank) obsBlankLines++;
      if (int'(Ypos) > obsMaxY) obsMaxY = int'(Ypos);
      if (frameStart) obsFsCount++;
    end
  endtask

  // Issue n line_end pulses separated by random idle gaps.
  task automatic runLines(input int n, input int maxGap);
    for (int i = 0; i < n; i++) begin
      int gap;
      gap = $urandom_range(maxGap, 0);
      for (int g = 0; g < gap; g++) applyStimulus(1'b0, 1'b0);
      applyStimulus(1'b1, 1'b0);
    end
  endtask

  // Advance at least one line, then until the model reaches the target index.
  task automatic runToIdx(input int target);
    bit reached;
    runLines(1, 1);
    reached = (mIdx == target);
    for (int k = 0; k < 4000 && !reached; k++) begin
      runLines(1, 1);
      reached = (mIdx == target);
    end
    checkOutput("runToIdx_reached", 32'(reached), 32'd1);
  endtask

  task automatic clearObs();
    obsVsyncLines = 0;
    obsBlankLines = 0;
    obsMaxY       = 0;
    obsFsCount    = 0;
  endtask

  task automatic setTiming(input int v, input int f, input int s, input int b);
    visIn  = W'(v);
    fpIn   = W'(f);
    syncIn = W'(s);
    bpIn   = W'(b);
  endtask

  // Main scenario sequence.
  initial begin
    lineEnd = 1'b0;
    rst     = 1'b1;
    setTiming(480, 10, 2, 33);
    clearObs();

    // Reset state, then the first-frame strobe after release.
    applyStimulus(1'b0, 1'b1);
    applyStimulus(1'b1, 1'b1);
    checkOutput("reset_vsync", 32'(vsync), 32'd1);
    checkOutput("reset_vblank", 32'(vblank), 32'd0);
    applyStimulus(1'b0, 1'b0);
    checkOutput("release_frame_start", 32'(frameStart), 32'd1);

    // One full 640x480 frame: 525 lines, 2 sync lines, 45 blank lines.
    clearObs();
    runLines(525, 1);
    checkOutput("vga_vsync_lines", 32'(obsVsyncLines), 32'd2);
    checkOutput("vga_blank_lines", 32'(obsBlankLines), 32'd45);
    checkOutput("vga_max_ypos", 32'(obsMaxY), 32'd479);
    checkOutput("vga_frame_starts", 32'(obsFsCount), 32'd1);
    checkOutput("vga_wrap_idx", 32'(mIdx), 32'd0);

    // Mid-frame reconfiguration: current frame keeps 480, next reaches 599.
    runToIdx(100);
    visIn = W'(600);
    clearObs();
    runToIdx(0);
    checkOutput("reconf_old_max", 32'(obsMaxY), 32'd479);
    visIn = W'(480);
    clearObs();
    runToIdx(0);
    checkOutput("reconf_new_max", 32'(obsMaxY), 32'd599);

    // Reset asserted while in sync at line 491, together with a line_end.
    runToIdx(491);
    checkOutput("pre_reset_vsync", 32'(vsync), 32'd0);
    applyStimulus(1'b1, 1'b1);
    checkOutput("midreset_vsync", 32'(vsync), 32'd1);
    checkOutput("midreset_vblank", 32'(vblank), 32'd0);
    checkOutput("midreset_ypos", 32'(Ypos), 32'd0);
    checkOutput("midreset_frame_cnt", 32'(frameCnt), 32'd0);
    applyStimulus(1'b0, 1'b0);
    checkOutput("midreset_release_fs", 32'(frameStart), 32'd1);

    // Zero-length porches: VIS(4) -> SYNC(2) -> VIS, frame of 6 lines.
    setTiming(4, 0, 2, 0);
    runToIdx(0);
    clearObs();
    runLines(12, 2);
    checkOutput("zero_frame_starts", 32'(obsFsCount), 32'd2);
    checkOutput("zero_vsync_lines", 32'(obsVsyncLines), 32'd4);

    // Back-to-back pulses from row 0.
    applyStimulus(1'b1, 1'b0);
    checkOutput("b2b_ypos1", 32'(Ypos), 32'd1);
    applyStimulus(1'b1, 1'b0);
    checkOutput("b2b_ypos2", 32'(Ypos), 32'd2);
    applyStimulus(1'b1, 1'b0);
    checkOutput("b2b_ypos3", 32'(Ypos), 32'd3);
    applyStimulus(1'b1, 1'b0);
    checkOutput("b2b_vblank", 32'(vblank), 32'd1);
    runToIdx(0);

    // Three full frames after reset with the short timing.
    applyStimulus(1'b0, 1'b1);
    runLines(18, 1);
    checkOutput("three_frames_idx", 32'(mIdx), 32'd0);
`ifdef VGA_VSYNC_FRAME_CNT_EN
    checkOutput("three_frames_cnt", 32'(frameCnt), 32'd3);
    force dut.frameCnt_q = 16'hFFFF;
    #1;
    release dut.frameCnt_q;
    mFrames = 16'hFFFF;
    runLines(6, 1);
    checkOutput("frame_cnt_wrap", 32'(frameCnt), 32'd0);
`else
    checkOutput("three_frames_cnt", 32'(frameCnt), 32'd0);
`endif

    // Randomised small timings, including zero visible and empty porches.
    for (int t = 0; t < 8; t++) begin
      setTiming($urandom_range(3, 0), $urandom_range(3, 0),
                $urandom_range(3, 0), $urandom_range(3, 0));
      applyStimulus(1'b0, 1'b1);
      runLines(40, 2);
      for (int q = 0; q < 5; q++) applyStimulus(1'b0, 1'b0);
    end

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

  // Global watchdog so the run always terminates.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] simulation time limit reached");
  end

endmodule

// File: doc/vga_vsync_gen.md
# vga_vsync_gen

Vertical timing stage of the VGA pipeline, directly downstream of the horizontal sync counter. Counts the one-cycle end-of-line pulses from the horizontal stage, walks a four-state vertical frame FSM, and produces the vertical pixel row, the vsync pin level, a vertical-blank flag and a frame-start strobe. The pixel/colour stage consumes these outputs together with the horizontal stage's outputs.

## Interface
- `W`, default 12: width of line counters and timing inputs.
- `VSYNC_POL`, default 0: level driven on `vsync` during the sync pulse; the idle level is its inverse.

- `clk`, input, 1: pixel clock, shared with the horizontal stage.
- `rst`, input, 1: synchronous, active-high reset.
- `line_end`, input, 1: one-cycle pulse from the horizontal stage on the last pixel clock of each line.
- `visible_lines`, input, W: number of active lines (e.g. 480).
- `front_porch`, input, W: number of front-porch lines.
- `sync_pulse`, input, W: number of vsync lines.
- `back_porch`, input, W: number of back-porch lines.
- `Ypos`, output, W: current visible row index; 0 outside the visible region.
- `vsync`, output, 1: vertical sync pin level.
- `vblank`, output, 1: 1 outside the visible region.
- `frame_start`, output, 1: one-cycle pulse on entry to row 0 of a frame.
- `frame_cnt`, output, 16: count of completed frames (see Configuration).

## Operation
- FSM states, in order: S_VIS, S_FP, S_SYNC, S_BP, then back to S_VIS.
- `line_cnt` (W bits) counts lines within the current state.
- Each `line_end` increments `line_cnt`. When `line_cnt == len-1` for the current state, `line_cnt` clears to 0 and the FSM advances to the next state.
- States whose length is 0 are skipped. The transition goes directly to the next nonzero-length state within the same cycle.
- `visible_lines == 0` is treated as 1.
- Timing inputs are latched into shadow registers while `rst` is high and on every S_BP→S_VIS transition (or the equivalent transition into S_VIS when porches are skipped).
  - Inputs changing mid-frame take effect from the next frame only.
- `Ypos` equals `line_cnt` in S_VIS and is 0 otherwise.
- `vblank` is 0 in S_VIS and 1 otherwise.
- `vsync` is VSYNC_POL in S_SYNC and ~VSYNC_POL otherwise.
- `frame_start` is 1 for exactly the cycle in which the FSM is in S_VIS with `line_cnt == 0` for the first time after the transition. It also fires once after reset release.
- Frame length is visible + front porch + sync + back porch lines, with zero-length porch/sync states contributing nothing.
- No arithmetic overflow is possible: all comparisons use W-bit shadow values and `line_cnt < len`.

## Timing
- Reset values: FSM in S_VIS, `line_cnt=0`, `Ypos=0`, `vblank=0`, `vsync=~VSYNC_POL`, `frame_start=0`, `frame_cnt=0`.
- `frame_start` asserts on the first clock after `rst` deasserts.
- All outputs are registered. Output changes caused by a `line_end` sampled at edge N are visible after edge N, so they align with the first pixel of the next line. Latency is 1 clock.
- `line_end` on consecutive cycles is legal; each pulse counts once.
- `line_end` high in the same cycle as `rst`: reset wins and the pulse is ignored.
- Reset mid-frame: the next edge forces the reset state regardless of FSM state. No partial-frame `frame_cnt` increment occurs.
- A `line_end` that is not followed by another leaves all outputs static indefinitely.

## Configuration
- `VGA_VSYNC_FRAME_CNT_EN` defined:
  - `frame_cnt` increments by 1, wrapping 0xFFFF→0, on every S_BP→S_VIS transition, i.e. in the same cycle `frame_start` asserts for frames after the first.
- `VGA_VSYNC_FRAME_CNT_EN` undefined:
  - The counter logic is not compiled.
  - `frame_cnt` is tied to 16'h0000; the port remains present.

## Test plan
- 640x480 timing: visible=480, fp=10, sync=2, bp=33, `line_end` every 800 clocks.
  - Frame period is 525 lines.
  - `vsync` low (VSYNC_POL=0) for exactly lines 490–491.
  - `vblank` is 1 for 45 lines.
  - `Ypos` runs 0..479.
- Zero-length states: fp=0, bp=0, sync=2, visible=4.
  - State sequence is VIS(4)→SYNC(2)→VIS.
  - Frame is 6 lines; `frame_start` fires every 6 `line_end` pulses.
- Mid-frame reconfiguration: change visible from 480 to 600 at line 100.
  - The current frame still uses 480.
  - The next frame's `Ypos` reaches 599.
- Reset: assert `rst` during S_SYNC at line 491.
  - One clock later: `vsync=1`, `vblank=0`, `Ypos=0`.
  - `frame_start=1` on the first clock after release.
  - `frame_cnt=0`.
- Back-to-back `line_end` on 3 consecutive clocks with visible=4.
  - `Ypos` goes 1, 2, 3 on successive cycles.
  - `vblank` rises on the following pulse.
- With `VGA_VSYNC_FRAME_CNT_EN` defined, run 3 full frames.
  - `frame_cnt` reads 3.
  - Preload via force to 0xFFFF, run one frame: `frame_cnt` reads 0.
  - With the macro undefined, `frame_cnt` stays 0 throughout.
